// File: rtl/ssdu_frame_rd.sv
// ssdu_frame_rd: rebuilds SOP/EOF frames from the extension-box CMM read FIFO and
// hands them to the SSDU transmitter; defining SSDU_CHKSUM_EN appends a 16-bit sum word.
module ssdu_frame_rd #(
   parameter logic [8:0] MAX_WORDS = 9'd256
) (
   input  logic        clk_12_5m,
   input  logic        rst_12_5m,
   input  logic        excmm_ssdu_empty,
   input  logic        excmm_ssdu_dval,
   input  logic [17:0] excmm_ssdu_data,
   output logic        ssdu_excmm_rdreq,
   input  logic        ssdu_tx_rdy,
   output logic        ssdu_tx_dval,
   output logic        ssdu_tx_sop,
   output logic        ssdu_tx_eop,
   output logic        ssdu_tx_err,
   output logic [15:0] ssdu_tx_data,
   output logic [15:0] frm_cnt,
   output logic [7:0]  err_cnt
);
   typedef enum logic [1:0] {IDLE, DATA, CHKSUM, DISCARD} state_t;
   state_t      state_q, state_d;
   logic [18:0] b0_q, b0_d, b1_q, b1_d, w;
   logic [1:0]  occ_q, occ_d, occ_p;
   logic [8:0]  cnt_q, cnt_d;
   logic [15:0] frm_q, frm_d;
   logic [7:0]  err_q, err_d, err_inc;
   logic        rdreq_q, rdreq_d, pend_q, push, pop, acc, take, sop, eof;
   logic [15:0] din;
`ifdef SSDU_CHKSUM_EN
   localparam logic EOF_EOP = 1'b0;
   logic [15:0] sum_q, sum_d;
`else
   localparam logic EOF_EOP = 1'b1;
`endif
   assign sop     = excmm_ssdu_data[17];
   assign eof     = excmm_ssdu_data[16];
   assign din     = excmm_ssdu_data[15:0];
   assign acc     = excmm_ssdu_dval && pend_q;
   assign take    = acc && ((state_q == IDLE && sop) || (state_q == DATA && !sop));
   assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   assign ssdu_excmm_rdreq = rdreq_q;
   assign ssdu_tx_dval     = occ_q != 2'd0;
   assign {ssdu_tx_sop, ssdu_tx_eop, ssdu_tx_err, ssdu_tx_data} = b0_q;
   assign frm_cnt = frm_q;
   assign err_cnt = err_q;
   // frame parser: decides what (if anything) is pushed this cycle and tracks counters
   always_comb begin
      push    = 1'b0;
      w       = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      frm_d   = frm_q;
      err_d   = err_q;
`ifdef SSDU_CHKSUM_EN
      sum_d   = sum_q;
`endif
      if (acc && state_q == IDLE && !sop) err_d = err_inc;
      if (acc && state_q == DATA && sop) begin
         push    = 1'b1;
         w       = {3'b011, 16'h0000};
         err_d   = err_inc;
         state_d = IDLE;
      end
      if (take) begin
         push    = 1'b1;
         w       = {sop, 2'b00, din};
         cnt_d   = sop ? 9'd1 : cnt_q + 9'd1;
         state_d = DATA;
`ifdef SSDU_CHKSUM_EN
         sum_d   = (sop ? 16'h0000 : sum_q) + din;
`endif
         if (eof) begin
            w[17] = EOF_EOP;
`ifdef SSDU_CHKSUM_EN
            state_d = CHKSUM;
`else
            frm_d   = frm_q + 16'd1;
            state_d = IDLE;
`endif
         end else if (!sop && cnt_q == MAX_WORDS - 9'd1) begin
            w[17:16] = 2'b11;
            err_d    = err_inc;
            state_d  = DISCARD;
         end
      end
`ifdef SSDU_CHKSUM_EN
      if (state_q == CHKSUM && occ_q != 2'd2) begin
         push    = 1'b1;
         w       = {3'b010, sum_q};
         frm_d   = frm_q + 16'd1;
         state_d = IDLE;
      end
`endif
      if (acc && state_q == DISCARD && eof) state_d = IDLE;
   end
   // two-entry output buffer; head entry is cleared when the buffer drains
   always_comb begin
      pop   = (occ_q != 2'd0) && ssdu_tx_rdy;
      occ_p = occ_q - {1'b0, pop};
      occ_d = occ_p + {1'b0, push};
      b0_d  = pop ? b1_q : b0_q;
      b1_d  = b1_q;
      if (push && occ_p == 2'd0) b0_d = w;
      if (push && occ_p != 2'd0) b1_d = w;
      if (occ_d == 2'd0) b0_d = '0;
      rdreq_d = !excmm_ssdu_empty && !rdreq_q && !(excmm_ssdu_dval && eof) &&
                state_q != CHKSUM && occ_d <= 2'd1;
   end
   // state registers
   always_ff @(posedge clk_12_5m) begin
      if (rst_12_5m) begin
         state_q <= IDLE;
         b0_q    <= '0;
         b1_q    <= '0;
         occ_q   <= '0;
         cnt_q   <= '0;
         frm_q   <= '0;
         err_q   <= '0;
         rdreq_q <= 1'b0;
         pend_q  <= 1'b0;
`ifdef SSDU_CHKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         frm_q   <= frm_d;
         err_q   <= err_d;
         rdreq_q <= rdreq_d;
         pend_q  <= rdreq_q;
`ifdef SSDU_CHKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
endmodule
